// File: rtl/led_pwm_driver.sv
// PWM brightness driver for the GPIO LED register; mask/duty are shadowed and swapped only at period boundaries.
// Optional blink gating is compiled in with `define LED_PWM_BLINK_EN.
module led_pwm_driver #(
    parameter int LED_WIDTH     = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 32
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic [LED_WIDTH-1:0] led_in,
    input  logic [PWM_BITS-1:0]  duty_in,
    input  logic                 duty_wr,
`ifdef LED_PWM_BLINK_EN
    input  logic                 blink_en,
`endif
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    if (PRESCALE < 1 || PRESCALE > 65535 || BLINK_PERIODS < 1) begin : g_bad_cfg
        $error("led_pwm_driver: illegal PRESCALE or BLINK_PERIODS");
    end

    logic [PS_W-1:0]      prescaler;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [LED_WIDTH-1:0] pend_mask;
    logic [PWM_BITS-1:0]  pend_duty;
    logic [LED_WIDTH-1:0] act_mask;
    logic [PWM_BITS-1:0]  act_duty;
    logic                 tick;
    logic                 boundary;
    logic                 blank;

    // Comparator: a pin is lit for the first 'duty' ticks of the period.
    function automatic logic [LED_WIDTH-1:0] pwm_gate(
        input logic [LED_WIDTH-1:0] mask,
        input logic [PWM_BITS-1:0]  cnt,
        input logic [PWM_BITS-1:0]  duty
    );
        return (cnt < duty) ? mask : '0;
    endfunction

    assign tick     = (prescaler == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_LAST);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (boundary) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Pending stage: mask follows the register, duty only on a write strobe.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pend_mask <= '0;
            pend_duty <= '0;
        end else begin
            pend_mask <= led_in;
            if (duty_wr) begin
                pend_duty <= duty_in;
            end
        end
    end

    // Active stage: a duty write landing in the boundary cycle bypasses the shadow.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            act_mask     <= '0;
            act_duty     <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary) begin
                act_mask <= pend_mask;
                act_duty <= duty_wr ? duty_in : pend_duty;
            end
        end
    end

`ifdef LED_PWM_BLINK_EN
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank = blink_en & blink_phase;
`else
    assign blank = 1'b0;
`endif

    // Output stage: one register between comparator and pins.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            led_out <= '0;
        end else begin
            led_out <= blank ? '0 : pwm_gate(act_mask, pwm_cnt, act_duty);
        end
    end

endmodule
